// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, requester ids and request bundle for the BRAM arbiter
//   ADDR_W/DATA_W : word-address and data widths of the instruction/data BRAM
//   req_id_t      : requester id (REQ_LOADER = UART loader / IO master, REQ_CORE = core)
//   mem_req_t     : one access as presented by a requester {we, addr, wdata}
package mem_pkg;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   typedef logic req_id_t;
   localparam req_id_t REQ_LOADER = 1'b0;
   localparam req_id_t REQ_CORE   = 1'b1;
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port of the BRAM arbiter
//   req/we/addr/wdata : access request, held stable by the requester until gnt
//   gnt               : request accepted this cycle
//   rvalid/rdata      : read data returned to this requester
//   master = requester side, slave = arbiter side
interface mem_arbiter_if;
   import mem_pkg::*;
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: LAT-deep shift register of {valid, id} tracking in-flight BRAM reads
//   clk, rstn        : clock, synchronous active-low clear of all tags
//   i_valid, i_id    : tag entering stage 0 (a granted read)
//   o_valid, o_id    : tag leaving the last stage, aligned with BRAM read data
module rd_tag_pipe import mem_pkg::*; #(
   parameter int LAT = 2
) (
   input  logic    clk,
   input  logic    rstn,
   input  logic    i_valid,
   input  req_id_t i_id,
   output logic    o_valid,
   output req_id_t o_id
);
   logic [LAT-1:0]    r_valid;
   req_id_t [LAT-1:0] r_id;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_valid <= '0;
         r_id    <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_id[0]    <= i_id;
         for (int k = 1; k < LAT; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_id[k]    <= r_id[k-1];
         end
      end
   end
   assign o_valid = r_valid[LAT-1];
   assign o_id    = r_id[LAT-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and read-return sequencer for the BRAM
//   clk, rstn      : clock, synchronous active-low reset
//   m0, m1         : requester ports (m0 = UART loader / IO master, m1 = core memory port)
//   mem_en/we/addr/wdata : BRAM drive, muxed from the granted requester in the same cycle
//   mem_rdata      : BRAM read data, valid LAT cycles after a read
//   conflict_cnt   : saturating count of cycles in which both requesters asked
module mem_arbiter import mem_pkg::*; #(
   parameter int LAT = 2
) (
   input  logic              clk,
   input  logic              rstn,
   mem_arbiter_if.slave      m0,
   mem_arbiter_if.slave      m1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       conflict_cnt
);
   req_id_t     r_last;
   logic [31:0] r_conflict_cnt;
   logic        w_gnt0, w_gnt1, w_both, w_tag_v;
   req_id_t     w_tag_id;
   mem_req_t    w_sel;

   if (LAT < 1 || LAT > 4) begin : g_lat_chk
      $error("mem_arbiter: LAT must be in 1..4");
   end

   // On a tie the requester that did not win last time is served.
   assign w_both = m0.req & m1.req;
   assign w_gnt0 = rstn & m0.req & (!m1.req | (r_last == REQ_CORE));
   assign w_gnt1 = rstn & m1.req & (!m0.req | (r_last == REQ_LOADER));
   assign w_sel  = w_gnt1 ? mem_req_t'{m1.we, m1.addr, m1.wdata}
                          : mem_req_t'{m0.we, m0.addr, m0.wdata};

   assign mem_en    = w_gnt0 | w_gnt1;
   assign mem_we    = mem_en & w_sel.we;
   assign mem_addr  = w_sel.addr;
   assign mem_wdata = w_sel.wdata;
   assign m0.gnt    = w_gnt0;
   assign m1.gnt    = w_gnt1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_last         <= REQ_CORE;
         r_conflict_cnt <= '0;
      end else begin
         if (mem_en) r_last <= w_gnt1 ? REQ_CORE : REQ_LOADER;
         if (w_both && r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end
   assign conflict_cnt = r_conflict_cnt;

   rd_tag_pipe #(.LAT(LAT)) u_tags (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (mem_en & ~w_sel.we),
      .i_id    (w_gnt1 ? REQ_CORE : REQ_LOADER),
      .o_valid (w_tag_v),
      .o_id    (w_tag_id)
   );

   // rstn gating keeps a tag that reaches the last stage in the reset cycle silent.
   assign m0.rvalid = rstn & w_tag_v & (w_tag_id == REQ_LOADER);
   assign m1.rvalid = rstn & w_tag_v & (w_tag_id == REQ_CORE);
   assign m0.rdata  = mem_rdata;
   assign m1.rdata  = mem_rdata;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and read-return sequencer in front of the single-ported instruction/data BRAM.
- Requester 0 is the UART program loader / IO master; requester 1 is the multicycle core's unified memory port, whose FSM already time-multiplexes fetch and load/store.
- Grants at most one access per cycle with round-robin fairness.
- Tracks in-flight reads through a fixed-latency tag pipeline so each read's data returns only to the requester that issued it.

Parameters:
ADDR_W, 15, word-address width
DATA_W, 32, data width
LAT, 2, BRAM read latency in cycles (legal range 1..4)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
m0_req  in  1  requester 0 access request, held until granted
m0_we  in  1  requester 0 write (1) / read (0)
m0_addr  in  ADDR_W  requester 0 word address
m0_wdata  in  DATA_W  requester 0 write data
m0_gnt  out  1  requester 0 request accepted this cycle
m0_rvalid  out  1  requester 0 read data valid
m0_rdata  out  DATA_W  requester 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for requester 1
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, valid LAT cycles after a read
conflict_cnt  out  32  saturating count of cycles in which both requesters asked

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
- Reset values:
  - last_grant = 1, so requester 0 wins the first tie.
  - Tag pipeline cleared.
  - conflict_cnt = 0.
  - All gnt/rvalid/mem_en/mem_we = 0 while rstn is low.
- Grant logic (combinational, same cycle as req):
  - Exactly one requester → grant it.
  - Both requesters → grant the one not equal to last_grant.
  - Neither → no grant, mem_en = 0.
- last_grant updates at the clock edge to the granted id; it holds when nothing is granted.
- Memory drive: mem_en = any grant. mem_we, mem_addr and mem_wdata are muxed from the granted requester in the same cycle (zero added latency).
- Requester rule: req, we, addr and wdata stay stable until the cycle gnt is seen. The arbiter accepts a new request the cycle after a grant (full throughput, one per cycle).
- Tag pipeline:
  - LAT-stage shift register of {valid, id}.
  - Stage 0 loads {1, granted id} on a granted read, else {0, x}.
  - Writes never enter as valid.
- Read return:
  - mX_rvalid = last-stage valid && id == X.
  - mX_rdata = mem_rdata, unregistered.
  - Exactly LAT cycles after gnt; returns are in order; at most one return per cycle.
- Non-returning requester: its rdata is don't-care; its rvalid must be 0.
- conflict_cnt: increments on every cycle with m0_req && m1_req; saturates at 0xFFFFFFFF without wrapping.
- Boundary conditions:
  - Write then read of the same address on consecutive cycles: the read returns the new data (BRAM write-first behaviour is not relied on; the accesses occur in different cycles).
  - Reset asserted with reads in flight: all tags are dropped and no rvalid is produced afterwards.
  - Request present during reset: not granted until the first cycle with rstn high.
  - LAT outside 1..4: elaboration-time assertion failure.

Decomposition:
- Package mem_pkg holds:
  - typedef mem_req_t {we, addr, wdata}
  - typedef req_id_t (1 bit)
  - localparams ADDR_W, DATA_W
  - the constant REQ_LOADER = 0, REQ_CORE = 1
- One sub-module, rd_tag_pipe: parameterised LAT-deep shift register of {valid, id} with synchronous clear.

Test Plan:
- Single read, LAT=2: m1 reads 0x010 (holding 0xDEADBEEF) → m1_gnt in cycle 0; m1_rvalid=1 with rdata=0xDEADBEEF in cycle 2 only; m0_rvalid stays 0.
- Contention from reset: m0 and m1 both request reads continuously → grants alternate m0, m1, m0, m1; each rvalid lands on its owner 2 cycles later; conflict_cnt=4 after 4 cycles.
- Streaming: m1 reads 0x000, 0x001, 0x002 back-to-back with m0 idle → 3 consecutive gnts; rvalid in cycles 2, 3, 4 with data in address order.
- Write-then-read: m0 writes 0x0000_1234 to 0x020, then reads 0x020 → no rvalid for the write; read returns 0x0000_1234.
- Reset mid-flight: issue 2 reads, assert rstn=0 the next cycle for 1 cycle → no rvalid ever appears; last_grant is back at 1, so a tie after reset is granted to m0.
- Saturation: force conflict_cnt to 0xFFFFFFFE, hold both requests for 3 cycles → count reads 0xFFFFFFFF and holds.
